// File: rtl/syzygy_adc_pkg.sv
// Shared types and default parameters for the SYZYGY ADC frame-alignment controller.
package syzygy_adc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CHECK,
        SLIP,
        LOCKED,
        FAIL
    } ch_state_e;

    localparam int unsigned DEF_NUM_CH        = 4;
    localparam int unsigned DEF_WORD_W        = 8;
    localparam logic [7:0]  DEF_PATTERN       = 8'hF0;
    localparam int unsigned DEF_SETTLE_CYCLES = 4;
    localparam int unsigned DEF_MATCH_COUNT   = 16;
    localparam int unsigned DEF_MAX_SLIPS     = 8;

endpackage

// File: rtl/syzygy_adc_frame_align_ch.sv
// One channel of frame alignment: settle, compare against the training word, bitslip until
// aligned or the slip budget is exhausted.
module syzygy_adc_frame_align_ch
    import syzygy_adc_pkg::*;
#(
    parameter int unsigned       WORD_W        = DEF_WORD_W,
    parameter logic [WORD_W-1:0] PATTERN       = WORD_W'(DEF_PATTERN),
    parameter int unsigned       SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned       MATCH_COUNT   = DEF_MATCH_COUNT,
    parameter int unsigned       MAX_SLIPS     = DEF_MAX_SLIPS
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [WORD_W-1:0]                data,
    output logic                             bitslip,
    output logic                             locked,
    output logic                             error,
    output logic                             active,
`ifdef SYZYGY_ADC_FRAME_ALIGN_SLIP_COUNT_EN
    output logic [$clog2(MAX_SLIPS+1)-1:0]   slip_count,
`endif
    output logic                             finish_c
);

    localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned MATCH_W  = $clog2(MATCH_COUNT + 1);
    localparam int unsigned SLIP_W   = $clog2(MAX_SLIPS + 1);

    ch_state_e           state;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [MATCH_W-1:0]  match_cnt;
    logic [SLIP_W-1:0]   slip_cnt;
    logic                match_c;
    logic                last_match_c;
    logic                slips_spent_c;

    assign match_c       = (data == PATTERN);
    assign last_match_c  = (match_cnt == MATCH_W'(MATCH_COUNT - 1));
    assign slips_spent_c = (slip_cnt == SLIP_W'(MAX_SLIPS));

    // Channel leaves training on this edge; lets the top register busy/done without lag.
    assign finish_c = (state == CHECK) && (match_c ? last_match_c : slips_spent_c);

`ifdef SYZYGY_ADC_FRAME_ALIGN_SLIP_COUNT_EN
    assign slip_count = slip_cnt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            settle_cnt <= '0;
            match_cnt  <= '0;
            slip_cnt   <= '0;
            bitslip    <= 1'b0;
            locked     <= 1'b0;
            error      <= 1'b0;
            active     <= 1'b0;
        end else begin
            bitslip <= 1'b0;
            case (state)
                IDLE, LOCKED, FAIL: begin
                    if (start) begin
                        state      <= SETTLE;
                        settle_cnt <= '0;
                        match_cnt  <= '0;
                        slip_cnt   <= '0;
                        locked     <= 1'b0;
                        error      <= 1'b0;
                        active     <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                        state      <= CHECK;
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + SETTLE_W'(1);
                    end
                end
                CHECK: begin
                    if (match_c) begin
                        if (last_match_c) begin
                            state     <= LOCKED;
                            match_cnt <= MATCH_W'(MATCH_COUNT);
                            locked    <= 1'b1;
                            active    <= 1'b0;
                        end else begin
                            match_cnt <= match_cnt + MATCH_W'(1);
                        end
                    end else begin
                        match_cnt <= '0;
                        if (slips_spent_c) begin
                            state  <= FAIL;
                            error  <= 1'b1;
                            active <= 1'b0;
                        end else begin
                            state   <= SLIP;
                            bitslip <= 1'b1;
                        end
                    end
                end
                SLIP: begin
                    state      <= SETTLE;
                    settle_cnt <= '0;
                    slip_cnt   <= slip_cnt + SLIP_W'(1);
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/syzygy_adc_frame_align.sv
// Multi-channel SYZYGY ADC frame-alignment controller: start gating and busy/done aggregation.
// Define SYZYGY_ADC_FRAME_ALIGN_SLIP_COUNT_EN to expose per-channel slip counters.
module syzygy_adc_frame_align
    import syzygy_adc_pkg::*;
#(
    parameter int unsigned       NUM_CH        = DEF_NUM_CH,
    parameter int unsigned       WORD_W        = DEF_WORD_W,
    parameter logic [WORD_W-1:0] PATTERN       = WORD_W'(DEF_PATTERN),
    parameter int unsigned       SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned       MATCH_COUNT   = DEF_MATCH_COUNT,
    parameter int unsigned       MAX_SLIPS     = DEF_MAX_SLIPS
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     start,
    input  logic [NUM_CH*WORD_W-1:0]                 data_in,
    output logic [NUM_CH-1:0]                        bitslip,
    output logic [NUM_CH-1:0]                        locked,
    output logic [NUM_CH-1:0]                        error,
`ifdef SYZYGY_ADC_FRAME_ALIGN_SLIP_COUNT_EN
    output logic [NUM_CH*$clog2(MAX_SLIPS+1)-1:0]    slip_count,
`endif
    output logic                                     busy,
    output logic                                     done
);

`ifdef SYZYGY_ADC_FRAME_ALIGN_SLIP_COUNT_EN
    localparam int unsigned SLIP_W = $clog2(MAX_SLIPS + 1);
`endif

    logic              go_c;
    logic              busy_nxt_c;
    logic [NUM_CH-1:0] ch_active;
    logic [NUM_CH-1:0] ch_finish_c;

    // A start arriving while any channel trains is dropped so no channel restarts mid-run.
    assign go_c = start & ~busy;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        syzygy_adc_frame_align_ch #(
            .WORD_W        (WORD_W),
            .PATTERN       (PATTERN),
            .SETTLE_CYCLES (SETTLE_CYCLES),
            .MATCH_COUNT   (MATCH_COUNT),
            .MAX_SLIPS     (MAX_SLIPS)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .start      (go_c),
            .data       (data_in[i*WORD_W +: WORD_W]),
            .bitslip    (bitslip[i]),
            .locked     (locked[i]),
            .error      (error[i]),
            .active     (ch_active[i]),
`ifdef SYZYGY_ADC_FRAME_ALIGN_SLIP_COUNT_EN
            .slip_count (slip_count[i*SLIP_W +: SLIP_W]),
`endif
            .finish_c   (ch_finish_c[i])
        );
    end

    assign busy_nxt_c = go_c | (|(ch_active & ~ch_finish_c));

    // busy tracks the channels' next state so done lines up with the last lock/error edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_nxt_c;
            done <= busy & ~busy_nxt_c;
        end
    end

endmodule
